// File: rtl/filter_pkg.sv
// Shared types and constants for the sample-stream filter blocks.
package filter_pkg;

    localparam int unsigned SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_HOLD = 2'd1,
        EMIT_MID  = 2'd2
    } state_t;

    localparam int unsigned ROUND_TRUNC   = 0;
    localparam int unsigned ROUND_HALF_UP = 1;

endpackage

// File: rtl/fir_interp2_mid.sv
// Combinational midpoint of two unsigned samples, computed one bit wider so it never wraps.
module fir_interp2_mid
    import filter_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned ROUND = ROUND_TRUNC
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mid
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rnd;

    assign rnd = (ROUND == ROUND_HALF_UP) ? (WIDTH+1)'(1) : '0;
    // Max is 2*(2^W-1)+1 = 2^(W+1)-1, which still fits in W+1 bits.
    assign sum = {1'b0, a} + {1'b0, b} + rnd;
    assign mid = WIDTH'(sum >> 1);

endmodule

// File: rtl/fir_interp2.sv
// 2x interpolator: each input sample yields a hold sample (previous input) and a midpoint.
module fir_interp2
    import filter_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned ROUND = ROUND_TRUNC
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] mid;
    logic             in_xfer;
    logic             out_xfer;

    fir_interp2_mid #(
        .WIDTH (WIDTH),
        .ROUND (ROUND)
    ) u_mid (
        .a   (prev_q),
        .b   (cur_q),
        .mid (mid)
    );

    // out_ready reaches in_ready combinationally so a new sample lands with the last output.
    always_comb begin
        in_ready = 1'b0;
        if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else if (state_q == EMIT_MID) begin
            in_ready = out_ready;
        end
    end

    assign out_valid = (state_q != IDLE);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        out_data = prev_q;
        if (state_q == EMIT_MID) begin
            out_data = mid;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            prev_q  <= '0;
            cur_q   <= '0;
        end else begin
            if (in_xfer) begin
                prev_q <= cur_q;
                cur_q  <= in_data;
            end
            unique case (state_q)
                IDLE: begin
                    if (in_xfer) state_q <= EMIT_HOLD;
                end
                EMIT_HOLD: begin
                    if (out_xfer) state_q <= EMIT_MID;
                end
                EMIT_MID: begin
                    if (out_xfer) state_q <= in_xfer ? EMIT_HOLD : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: truncating and round-half-up instances share one stimulus.
module tb_fir_interp2;
    import filter_pkg::*;

    logic       CLK;
    logic       RSTN;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready_t, in_ready_r;
    logic       out_valid_t, out_valid_r;
    logic [7:0] out_data_t, out_data_r;

    int n_cmp = 0;
    int n_err = 0;

    fir_interp2 #(.WIDTH(8), .ROUND(ROUND_TRUNC)) dut_t (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .in_valid  (in_valid),
        .in_ready  (in_ready_t),
        .in_data   (in_data),
        .out_valid (out_valid_t),
        .out_ready (out_ready),
        .out_data  (out_data_t)
    );

    fir_interp2 #(.WIDTH(8), .ROUND(ROUND_HALF_UP)) dut_r (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .in_valid  (in_valid),
        .in_ready  (in_ready_r),
        .in_data   (in_data),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_data  (out_data_r)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks the truncating instance after inputs settle.
    task automatic expect_t(input string tag, input logic v, input logic [7:0] d, input logic r);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid_t), 32'(v));
        if (v) chk({tag, ".out_data"}, 32'(out_data_t), 32'(d));
        chk({tag, ".in_ready"}, 32'(in_ready_t), 32'(r));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        @(negedge CLK);
        RSTN = 1'b0;
        #3;
        RSTN = 1'b1;
        tick();
    endtask

    initial begin
        RSTN      = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        #2;
        RSTN = 1'b0;
        #1;
        chk("reset.out_valid_async", 32'(out_valid_t), 32'd0);
        do_reset();

        // 1: 4, 8 at full rate -> 0, 2, 4, 6 with no bubble
        in_valid = 1'b1; in_data = 8'd4;
        expect_t("t1.c0", 1'b0, 8'd0, 1'b1);
        tick();
        in_data = 8'd8;
        expect_t("t1.c1", 1'b1, 8'd0, 1'b0);
        tick();
        expect_t("t1.c2", 1'b1, 8'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_t("t1.c3", 1'b1, 8'd4, 1'b0);
        tick();
        expect_t("t1.c4", 1'b1, 8'd6, 1'b1);
        tick();
        expect_t("t1.c5", 1'b0, 8'd0, 1'b1);

        // 2: saturation, 255 then 255 -> 0, 127, 255, 255
        do_reset();
        in_valid = 1'b1; in_data = 8'd255;
        tick();
        in_data = 8'd255;
        expect_t("t2.hold0", 1'b1, 8'd0, 1'b0);
        tick();
        expect_t("t2.mid0", 1'b1, 8'd127, 1'b1);
        chk("t2.mid0_round", 32'(out_data_r), 32'd128);
        tick();
        in_valid = 1'b0;
        expect_t("t2.hold1", 1'b1, 8'd255, 1'b0);
        tick();
        expect_t("t2.mid1", 1'b1, 8'd255, 1'b1);
        chk("t2.mid1_round", 32'(out_data_r), 32'd255);
        tick();

        // 3: 1 then 2 -> trunc 0,0,1,1 ; round 0,1,1,2
        do_reset();
        in_valid = 1'b1; in_data = 8'd1;
        tick();
        in_data = 8'd2;
        expect_t("t3.hold0", 1'b1, 8'd0, 1'b0);
        chk("t3.hold0_round", 32'(out_data_r), 32'd0);
        tick();
        expect_t("t3.mid0", 1'b1, 8'd0, 1'b1);
        chk("t3.mid0_round", 32'(out_data_r), 32'd1);
        tick();
        in_valid = 1'b0;
        expect_t("t3.hold1", 1'b1, 8'd1, 1'b0);
        chk("t3.hold1_round", 32'(out_data_r), 32'd1);
        tick();
        expect_t("t3.mid1", 1'b1, 8'd1, 1'b1);
        chk("t3.mid1_round", 32'(out_data_r), 32'd2);
        tick();

        // 4: backpressure in EMIT_HOLD, in_valid held high must not be accepted
        do_reset();
        in_valid = 1'b1; in_data = 8'd10;
        tick();
        out_ready = 1'b0;
        in_data = 8'd99;
        for (int i = 0; i < 3; i++) begin
            expect_t($sformatf("t4.stall%0d", i), 1'b1, 8'd0, 1'b0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        expect_t("t4.hold", 1'b1, 8'd0, 1'b0);
        tick();
        expect_t("t4.mid", 1'b1, 8'd5, 1'b1);
        tick();

        // 5: idle gap, then 20 after history 10 -> 10, 15
        for (int i = 0; i < 2; i++) begin
            expect_t($sformatf("t5.idle%0d", i), 1'b0, 8'd0, 1'b1);
            tick();
        end
        in_valid = 1'b1; in_data = 8'd20;
        tick();
        in_valid = 1'b0;
        expect_t("t5.hold", 1'b1, 8'd10, 1'b0);
        tick();
        expect_t("t5.mid", 1'b1, 8'd15, 1'b1);

        // 6: async reset in EMIT_MID, then 6 -> 0, 3
        out_ready = 1'b0;
        #2;
        RSTN = 1'b0;
        #1;
        chk("t6.out_valid_async", 32'(out_valid_t), 32'd0);
        #1;
        RSTN = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'd6;
        expect_t("t6.idle", 1'b0, 8'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_t("t6.hold", 1'b1, 8'd0, 1'b0);
        tick();
        expect_t("t6.mid", 1'b1, 8'd3, 1'b1);
        tick();
        expect_t("t6.done", 1'b0, 8'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
